// File: rtl/uart_lite_pkg.sv
// Shared constants for the AXI UART Lite driver: register map, STAT bits, CTRL init value, FSM states.
// No logic; pure declarations.
// Imported by uart_lite_ctrl.
package uart_lite_pkg;

    // AXI UART Lite register offsets
    localparam int UL_RX   = 'h0;
    localparam int UL_TX   = 'h4;
    localparam int UL_STAT = 'h8;
    localparam int UL_CTRL = 'hC;

    // STAT register bit positions
    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_FULL  = 3;

    // CTRL value that resets both peripheral FIFOs
    localparam int UL_CTRL_INIT = 'h3;

    // Controller states; ST_DEC spends one cycle acting on the latched STAT value
    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_INIT_W = 3'd1,
        ST_IDLE   = 3'd2,
        ST_STAT_W = 3'd3,
        ST_DEC    = 3'd4,
        ST_RX_W   = 3'd5,
        ST_TX_W   = 3'd6
    } ul_state_e;

endpackage

// File: rtl/uart_lite_byte_fifo.sv
// Synchronous 8-bit circular FIFO with wrap-bit pointers; head entry is read combinationally.
// Latency: push visible at pop_data the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep the count.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values; the extra MSB wraps modulo 2*DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since empty gates rx_valid
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_lite_ctrl.sv
// Drives axi_master to move core bytes to/from an AXI UART Lite (init CTRL, poll STAT, read RX, write TX).
// Latency: byte reaches we 2 cycles after the STAT r_success that permits it; RX byte visible the cycle after its read completes.
// Backpressure: tx_ready low while the 1-byte holding register is full or init is pending; RX polling stops when the RX buffer is full.
module uart_lite_ctrl
    import uart_lite_pkg::*;
#(
    parameter int AXI_DATAW = 32,
    parameter int AXI_ADDRW = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_valid,
    input  logic [7:0]             tx_data,
    output logic                   tx_ready,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic                   err_timeout,
    output logic                   re,
    output logic [AXI_ADDRW-1:0]   araddr_in,
    input  logic                   r_success,
    input  logic                   r_timeout,
    input  logic [AXI_DATAW-1:0]   rdata_out,
    output logic                   we,
    output logic [AXI_ADDRW-1:0]   awaddr_in,
    output logic [AXI_DATAW-1:0]   wdata_in,
    output logic [AXI_DATAW/8-1:0] wstrb_in,
    input  logic                   w_success,
    input  logic                   w_busy
);
    ul_state_e              state_q, state_d;
    logic                   stat_rxv_q, stat_rxv_d;
    logic                   stat_txf_q, stat_txf_d;
    logic                   tx_full_q, tx_full_d;
    logic [7:0]             tx_byte_q, tx_byte_d;
    logic                   err_q, err_d;
    logic                   re_q, re_d;
    logic                   we_q, we_d;
    logic [AXI_ADDRW-1:0]   araddr_q, araddr_d;
    logic [AXI_ADDRW-1:0]   awaddr_q, awaddr_d;
    logic [AXI_DATAW-1:0]   wdata_q, wdata_d;
    logic [AXI_DATAW/8-1:0] wstrb_q, wstrb_d;

    logic rx_push;
    logic rx_pop;
    logic rx_full;
    logic rx_empty;
    logic init_done;
    logic unused_inputs;

    // w_busy is advisory only; upper read-data bits carry nothing we use
    assign unused_inputs = ^{w_busy, rdata_out[AXI_DATAW-1:8]};

    assign init_done   = (state_q != ST_INIT) && (state_q != ST_INIT_W);
    assign tx_ready    = init_done && !tx_full_q;
    assign rx_valid    = !rx_empty;
    assign rx_pop      = rx_valid && rx_ready;
    assign err_timeout = err_q;
    assign re          = re_q;
    assign we          = we_q;
    assign araddr_in   = araddr_q;
    assign awaddr_in   = awaddr_q;
    assign wdata_in    = wdata_q;
    assign wstrb_in    = wstrb_q;

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rdata_out[7:0]),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // Next-state logic: one transaction at a time, address/data held until the next pulse
    always_comb begin
        state_d    = state_q;
        stat_rxv_d = stat_rxv_q;
        stat_txf_d = stat_txf_q;
        tx_full_d  = tx_full_q;
        tx_byte_d  = tx_byte_q;
        err_d      = err_q;
        re_d       = 1'b0;
        we_d       = 1'b0;
        araddr_d   = araddr_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rx_push    = 1'b0;

        if (tx_valid && tx_ready) begin
            tx_full_d = 1'b1;
            tx_byte_d = tx_data;
        end

        case (state_q)
            ST_INIT: begin
                we_d     = 1'b1;
                awaddr_d = AXI_ADDRW'(UL_CTRL);
                wdata_d  = AXI_DATAW'(UL_CTRL_INIT);
                wstrb_d  = '1;
                state_d  = ST_INIT_W;
            end
            ST_INIT_W: begin
                if (w_success) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (tx_full_q || !rx_full) begin
                    re_d     = 1'b1;
                    araddr_d = AXI_ADDRW'(UL_STAT);
                    state_d  = ST_STAT_W;
                end
            end
            ST_STAT_W: begin
                if (r_success) begin
                    stat_rxv_d = rdata_out[STAT_RX_VALID];
                    stat_txf_d = rdata_out[STAT_TX_FULL];
                    state_d    = ST_DEC;
                end else if (r_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DEC: begin
                // Draining the peripheral RX FIFO wins over sending
                if (stat_rxv_q && !rx_full) begin
                    re_d     = 1'b1;
                    araddr_d = AXI_ADDRW'(UL_RX);
                    state_d  = ST_RX_W;
                end else if (tx_full_q && !stat_txf_q) begin
                    we_d     = 1'b1;
                    awaddr_d = AXI_ADDRW'(UL_TX);
                    wdata_d  = {{(AXI_DATAW-8){1'b0}}, tx_byte_q};
                    wstrb_d  = {{(AXI_DATAW/8-1){1'b0}}, 1'b1};
                    state_d  = ST_TX_W;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX_W: begin
                if (r_success) begin
                    rx_push = 1'b1;
                    state_d = ST_IDLE;
                end else if (r_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_TX_W: begin
                if (w_success) begin
                    tx_full_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            stat_rxv_q <= 1'b0;
            stat_txf_q <= 1'b0;
            tx_full_q  <= 1'b0;
            tx_byte_q  <= '0;
            err_q      <= 1'b0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            araddr_q   <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            stat_rxv_q <= stat_rxv_d;
            stat_txf_q <= stat_txf_d;
            tx_full_q  <= tx_full_d;
            tx_byte_q  <= tx_byte_d;
            err_q      <= err_d;
            re_q       <= re_d;
            we_q       <= we_d;
            araddr_q   <= araddr_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_uart_lite_ctrl.sv
// Bench for uart_lite_ctrl: behavioural UART Lite peripheral + axi_master responder, core-side driver/monitor.
// Peripheral model: rx_q holds bytes waiting in the UART, tx_full_force drives STAT.TX_FULL, tx_out collects sent bytes.
// Every bus transaction is logged in completion order for ordering and latency checks.
module tb_uart_lite_ctrl;
    localparam int AXI_DATAW = 32;
    localparam int AXI_ADDRW = 4;
    localparam int RX_DEPTH  = 4;
    localparam int BOUND     = 2000;

    typedef struct {
        bit          is_wr;
        bit          to;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
        int          rcyc;
    } txn_t;

    logic clk;
    logic rst;
    logic tx_valid, tx_ready;
    logic [7:0] tx_data;
    logic rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic err_timeout;
    logic re, we;
    logic [AXI_ADDRW-1:0] araddr_in, awaddr_in;
    logic r_success, r_timeout, w_success, w_busy;
    logic [AXI_DATAW-1:0] rdata_out, wdata_in;
    logic [AXI_DATAW/8-1:0] wstrb_in;

    txn_t       log_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_out[$];
    logic [7:0] rx_got[$];
    bit tx_full_force, timeout_next_stat, timeout_next_rx, rand_run;
    int checks, errors, proto_err, cyc;

    uart_lite_ctrl #(.AXI_DATAW(AXI_DATAW), .AXI_ADDRW(AXI_ADDRW), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .err_timeout(err_timeout),
        .re(re), .araddr_in(araddr_in), .r_success(r_success), .r_timeout(r_timeout), .rdata_out(rdata_out),
        .we(we), .awaddr_in(awaddr_in), .wdata_in(wdata_in), .wstrb_in(wstrb_in),
        .w_success(w_success), .w_busy(w_busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Core-side RX consumer monitor
    initial forever begin
        @(negedge clk);
        if (!rst && rx_valid && rx_ready) rx_got.push_back(rx_data);
    end

    // Random environment churn for the mixed-traffic scenario
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_run) begin
            tx_full_force = ($urandom_range(0, 3) == 0);
            rx_ready      = 1'($urandom_range(0, 1));
        end
    end

    // axi_master + UART Lite peripheral model; also polices one-outstanding and hold-stable rules
    initial begin : responder
        txn_t t;
        int   lat;
        bit   abort;
        r_success = 0; r_timeout = 0; w_success = 0; w_busy = 0; rdata_out = 0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (re && we) proto_err++;
            if (re || we) begin
                t.is_wr = we;
                t.to    = 0;
                t.addr  = we ? awaddr_in : araddr_in;
                t.data  = wdata_in;
                t.strb  = wstrb_in;
                t.cyc   = cyc;
                w_busy  = we;
                lat     = $urandom_range(1, 4);
                abort   = 0;
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if (rst) begin abort = 1; break; end
                    if (re || we) proto_err++;
                    if (t.is_wr ? (awaddr_in !== t.addr || wdata_in !== t.data || wstrb_in !== t.strb)
                                : (araddr_in !== t.addr)) proto_err++;
                end
                if (!abort) begin
                    @(posedge clk);
                    #1;
                    t.rcyc = cyc;
                    if (t.is_wr) begin
                        if (t.addr == 4'h4) tx_out.push_back(t.data[7:0]);
                        w_success = 1;
                    end else if (t.addr == 4'h8 && timeout_next_stat) begin
                        timeout_next_stat = 0; t.to = 1; r_timeout = 1;
                    end else if (t.addr == 4'h0 && timeout_next_rx) begin
                        timeout_next_rx = 0; t.to = 1; r_timeout = 1;
                    end else if (t.addr == 4'h8) begin
                        t.data = {28'b0, tx_full_force, 2'b00, (rx_q.size() != 0)};
                        rdata_out = t.data; r_success = 1;
                    end else if (t.addr == 4'h0) begin
                        t.data = (rx_q.size() != 0) ? {24'($urandom()), rx_q.pop_front()} : 32'h0;
                        rdata_out = t.data; r_success = 1;
                    end else begin
                        t.data = 0; rdata_out = 0; r_success = 1;
                    end
                    log_q.push_back(t);
                    @(posedge clk);
                    #1;
                    r_success = 0; r_timeout = 0; w_success = 0;
                end
                w_busy = 0;
            end
        end
    end

    function automatic int find_stat(int from, logic [31:0] val);
        for (int i = from; i < log_q.size(); i++)
            if (!log_q[i].is_wr && !log_q[i].to && log_q[i].addr == 4'h8 && log_q[i].data == val) return i;
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(posedge clk); #1;
        tx_valid = 1; tx_data = b;
        forever begin
            @(negedge clk);
            if (tx_ready) break;
            n++;
            if (n > BOUND) begin
                checks++; errors++;
                $display("FAIL send_byte: tx_ready never rose, got 0 required 1");
                break;
            end
        end
        @(posedge clk); #1;
        tx_valid = 0;
    endtask

    task automatic test_reset();
        int n = 0;
        int bad = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_ready !== 1'b0)    begin errors++; $display("FAIL rst_tx_ready got %b required 0", tx_ready); end
        checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL rst_rx_valid got %b required 0", rx_valid); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b required 0", err_timeout); end
        checks++; if (re !== 1'b0 || we !== 1'b0) begin errors++; $display("FAIL rst_re_we got %b%b required 00", re, we); end
        checks++; if (araddr_in !== '0 || awaddr_in !== '0) begin errors++; $display("FAIL rst_addr got %h/%h required 0/0", araddr_in, awaddr_in); end
        checks++; if (wdata_in !== '0 || wstrb_in !== '0) begin errors++; $display("FAIL rst_wdata got %h/%h required 0/0", wdata_in, wstrb_in); end
        @(posedge clk); #1;
        rst = 0;
        while (log_q.size() == 0 && n < BOUND) begin
            @(negedge clk);
            if (tx_ready !== 1'b0) bad++;
            n++;
        end
        checks++;
        if (log_q.size() == 0) begin errors++; $display("FAIL init_write: no transaction, got 0 required 1"); end
        else if (!log_q[0].is_wr || log_q[0].addr !== 4'hC || log_q[0].data !== 32'h3 || log_q[0].strb !== 4'hF) begin
            errors++;
            $display("FAIL init_write got wr=%0d addr=%h data=%h strb=%h required wr=1 addr=c data=3 strb=f",
                     log_q[0].is_wr, log_q[0].addr, log_q[0].data, log_q[0].strb);
        end
        checks++; if (bad != 0 || tx_ready !== 1'b0) begin errors++; $display("FAIL init_tx_ready_low got %0d high cycles required 0", bad + int'(tx_ready)); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL init_tx_ready_rise got %b required 1", tx_ready); end
    endtask

    task automatic test_tx_single();
        int base, n, idx;
        tx_full_force = 0; rx_ready = 1;
        base = tx_out.size();
        send_byte(8'h41);
        n = 0;
        while (tx_out.size() == base && n < BOUND) begin @(negedge clk); n++; end
        checks++;
        if (tx_out.size() == base) begin errors++; $display("FAIL tx_single: no TX write, got 0 required 1"); end
        else begin
            idx = log_q.size() - 1;
            if (log_q[idx].addr !== 4'h4 || log_q[idx].data !== 32'h41 || log_q[idx].strb !== 4'h1) begin
                errors++;
                $display("FAIL tx_single got addr=%h data=%h strb=%h required addr=4 data=41 strb=1",
                         log_q[idx].addr, log_q[idx].data, log_q[idx].strb);
            end
            checks++;
            if (log_q[idx].cyc - log_q[idx-1].rcyc != 2) begin
                errors++;
                $display("FAIL tx_latency got %0d required 2", log_q[idx].cyc - log_q[idx-1].rcyc);
            end
            checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL tx_ready_busy got %b required 0", tx_ready); end
            @(negedge clk);
            checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL tx_ready_return got %b required 1", tx_ready); end
        end
    endtask

    task automatic test_tx_full_backoff();
        int base_out, base_log, n, stats;
        tx_full_force = 1;
        base_out = tx_out.size();
        send_byte(8'h77);
        base_log = log_q.size();
        n = 0; stats = 0;
        while (stats < 4 && n < BOUND) begin
            @(negedge clk); n++;
            stats = 0;
            for (int i = base_log; i < log_q.size(); i++) if (!log_q[i].is_wr && log_q[i].addr == 4'h8) stats++;
        end
        checks++; if (stats < 4) begin errors++; $display("FAIL backoff_repoll got %0d polls required 4", stats); end
        checks++; if (tx_out.size() != base_out) begin errors++; $display("FAIL backoff_no_write got %0d writes required 0", tx_out.size() - base_out); end
        @(posedge clk); #1;
        tx_full_force = 0;
        n = 0;
        while (tx_out.size() == base_out && n < BOUND) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        checks++;
        if (tx_out.size() != base_out + 1) begin errors++; $display("FAIL backoff_single_write got %0d writes required 1", tx_out.size() - base_out); end
        else if (tx_out[base_out] !== 8'h77) begin errors++; $display("FAIL backoff_byte got %h required 77", tx_out[base_out]); end
    endtask

    task automatic test_rx_fill();
        logic [7:0] exp[$];
        int base_log, base_got, n, reads, sz;
        @(posedge clk); #1;
        rx_ready = 0;
        base_got = rx_got.size();
        base_log = log_q.size();
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            exp.push_back(8'($urandom()));
            rx_q.push_back(exp[i]);
        end
        n = 0; reads = 0;
        while (reads < RX_DEPTH && n < BOUND) begin
            @(negedge clk); n++;
            reads = 0;
            for (int i = base_log; i < log_q.size(); i++) if (!log_q[i].is_wr && !log_q[i].to && log_q[i].addr == 4'h0) reads++;
        end
        repeat (20) @(negedge clk);
        sz = log_q.size();
        repeat (20) @(negedge clk);
        reads = 0;
        for (int i = base_log; i < log_q.size(); i++) if (!log_q[i].is_wr && !log_q[i].to && log_q[i].addr == 4'h0) reads++;
        checks++; if (reads != RX_DEPTH) begin errors++; $display("FAIL rx_fill_reads got %0d required %0d", reads, RX_DEPTH); end
        checks++; if (log_q.size() != sz) begin errors++; $display("FAIL rx_full_quiet got %0d txns required 0", log_q.size() - sz); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== exp[0]) begin errors++; $display("FAIL rx_head got %b/%h required 1/%h", rx_valid, rx_data, exp[0]); end
        @(posedge clk); #1;
        rx_ready = 1;
        n = 0;
        while (rx_got.size() - base_got < RX_DEPTH + 1 && n < BOUND) begin @(negedge clk); n++; end
        checks++;
        if (rx_got.size() - base_got != RX_DEPTH + 1) begin errors++; $display("FAIL rx_drain_count got %0d required %0d", rx_got.size() - base_got, RX_DEPTH + 1); end
        else for (int i = 0; i < RX_DEPTH + 1; i++) begin
            checks++;
            if (rx_got[base_got+i] !== exp[i]) begin errors++; $display("FAIL rx_drain_%0d got %h required %h", i, rx_got[base_got+i], exp[i]); end
        end
    endtask

    task automatic test_rx_before_tx();
        logic [7:0] b, r1, r2;
        int base, base_got, base_out, n, idx;
        b = 8'($urandom()); r1 = 8'($urandom()); r2 = 8'($urandom());
        rx_ready = 1; tx_full_force = 1;
        base_got = rx_got.size(); base_out = tx_out.size();
        send_byte(b);
        base = log_q.size();
        @(posedge clk); #1;
        rx_q.push_back(r1);
        n = 0;
        while (rx_got.size() == base_got && n < BOUND) begin @(negedge clk); n++; end
        idx = find_stat(base, 32'h9);
        checks++;
        if (idx < 0 || idx + 1 >= log_q.size() || log_q[idx+1].is_wr || log_q[idx+1].addr != 4'h0) begin
            errors++; $display("FAIL stat9_rx_first got idx=%0d required an RX read after STAT 0x9", idx);
        end
        base = log_q.size();
        @(posedge clk); #1;
        rx_q.push_back(r2); tx_full_force = 0;
        n = 0;
        while ((tx_out.size() == base_out || rx_got.size() < base_got + 2) && n < BOUND) begin @(negedge clk); n++; end
        idx = find_stat(base, 32'h1);
        checks++;
        if (idx < 0 || idx + 1 >= log_q.size() || log_q[idx+1].is_wr || log_q[idx+1].addr != 4'h0) begin
            errors++; $display("FAIL rx_priority got idx=%0d required an RX read ahead of the pending TX write", idx);
        end
        checks++;
        if (tx_out.size() != base_out + 1 || tx_out[base_out] !== b) begin errors++; $display("FAIL prio_tx_byte got %0d bytes required 1 byte %h", tx_out.size() - base_out, b); end
        checks++;
        if (rx_got.size() != base_got + 2 || rx_got[base_got] !== r1 || rx_got[base_got+1] !== r2) begin
            errors++; $display("FAIL prio_rx_bytes got %0d bytes required %h %h", rx_got.size() - base_got, r1, r2);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tx[$], exp_rx[$];
        int base_tx, base_rx, n;
        base_tx = tx_out.size(); base_rx = rx_got.size();
        rand_run = 1;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom());
                    exp_tx.push_back(b);
                    send_byte(b);
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [7:0] b;
                    repeat ($urandom_range(1, 30)) @(posedge clk);
                    #1;
                    b = 8'($urandom());
                    exp_rx.push_back(b);
                    rx_q.push_back(b);
                end
            end
        join
        rand_run = 0;
        @(posedge clk); #2;
        tx_full_force = 0; rx_ready = 1;
        n = 0;
        while ((tx_out.size() - base_tx < 12 || rx_got.size() - base_rx < 10) && n < BOUND) begin @(negedge clk); n++; end
        checks++;
        if (tx_out.size() - base_tx != 12 || rx_got.size() - base_rx != 10) begin
            errors++; $display("FAIL b2b_counts got tx=%0d rx=%0d required tx=12 rx=10", tx_out.size() - base_tx, rx_got.size() - base_rx);
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (tx_out[base_tx+i] !== exp_tx[i]) begin errors++; $display("FAIL b2b_tx_%0d got %h required %h", i, tx_out[base_tx+i], exp_tx[i]); end
            end
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rx_got[base_rx+i] !== exp_rx[i]) begin errors++; $display("FAIL b2b_rx_%0d got %h required %h", i, rx_got[base_rx+i], exp_rx[i]); end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] r;
        int n, base, base_got, to_rx;
        @(posedge clk); #1;
        timeout_next_stat = 1;
        n = 0;
        while (err_timeout !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL stat_timeout_err got %b required 1", err_timeout); end
        base = log_q.size();
        repeat (40) @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", err_timeout); end
        checks++; if (log_q.size() <= base) begin errors++; $display("FAIL repoll_after_timeout got %0d txns required >0", log_q.size() - base); end
        base = log_q.size(); base_got = rx_got.size();
        r = 8'($urandom());
        @(posedge clk); #1;
        timeout_next_rx = 1; rx_q.push_back(r);
        n = 0;
        while (rx_got.size() == base_got && n < BOUND) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        to_rx = 0;
        for (int i = base; i < log_q.size(); i++) if (log_q[i].to && log_q[i].addr == 4'h0) to_rx++;
        checks++; if (to_rx != 1) begin errors++; $display("FAIL rx_timeout_seen got %0d required 1", to_rx); end
        checks++;
        if (rx_got.size() != base_got + 1 || rx_got[base_got] !== r) begin
            errors++; $display("FAIL rx_after_timeout got %0d bytes required 1 byte %h", rx_got.size() - base_got, r);
        end
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (err_timeout !== 1'b0 || tx_ready !== 1'b0) begin errors++; $display("FAIL rst_clears_err got %b/%b required 0/0", err_timeout, tx_ready); end
        @(posedge clk); #1;
        rst = 0;
        n = 0;
        while (tx_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
        checks++; if (tx_ready !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL reinit got %b/%b required 1/0", tx_ready, err_timeout); end
    endtask

    initial begin
        rst = 1; tx_valid = 0; tx_data = 0; rx_ready = 0;
        test_reset();
        test_tx_single();
        test_tx_full_backoff();
        test_rx_fill();
        test_rx_before_tx();
        test_back_to_back();
        test_timeout();
        checks++;
        if (proto_err != 0) begin errors++; $display("FAIL bus_protocol got %0d violations required 0", proto_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
